// File: rtl/bus_xbar_rr_if.sv
// Flattened req/ack bus bundle between NM master agents and NS slave memories.
// Master/slave 0 occupy the LSBs of every packed vector.
interface bus_xbar_rr_if #(
    parameter int NM = 4,
    parameter int NS = 4,
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [NM-1:0]    m_req;
    logic [NM*AW-1:0] m_addr;
    logic [NM-1:0]    m_cmd;
    logic [NM*DW-1:0] m_wdata;
    logic [NM-1:0]    m_ack;
    logic [NM*DW-1:0] m_rdata;

    logic [NS-1:0]    s_req;
    logic [NS*AW-1:0] s_addr;
    logic [NS-1:0]    s_cmd;
    logic [NS*DW-1:0] s_wdata;
    logic [NS-1:0]    s_ack;
    logic [NS*DW-1:0] s_rdata;

    modport xbar (
        input  m_req, m_addr, m_cmd, m_wdata, s_ack, s_rdata,
        output m_ack, m_rdata, s_req, s_addr, s_cmd, s_wdata
    );

    modport master (
        output m_req, m_addr, m_cmd, m_wdata,
        input  m_ack, m_rdata
    );

    modport slave (
        input  s_req, s_addr, s_cmd, s_wdata,
        output s_ack, s_rdata
    );
endinterface

// File: rtl/bus_xbar_rr.sv
// NM x NS req/ack crossbar; each slave port has its own round-robin arbiter
// that locks the granted master until the slave acks.
module bus_xbar_rr #(
    parameter int NM = 4,
    parameter int NS = 4,
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    bus_xbar_rr_if.xbar   bus
);
    localparam int SW = $clog2(NS);
    localparam int GW = (NM > 1) ? $clog2(NM) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e          state_q [NS];
    logic [GW-1:0]   gnt_q   [NS];
    logic [GW-1:0]   ptr_q   [NS];

    logic [NM-1:0]   tgt     [NS];
    logic [GW-1:0]   pick    [NS];
    logic            found   [NS];

    // Target decode and rotating-priority search, one arbiter per slave.
    always_comb begin
        int unsigned idx;
        idx = 0;
        for (int unsigned j = 0; j < NS; j++) begin
            found[j] = 1'b0;
            pick[j]  = '0;
            for (int unsigned i = 0; i < NM; i++) begin
                tgt[j][i] = bus.m_req[i] &&
                            (bus.m_addr[i*AW + AW-1 -: SW] == SW'(j));
            end
            for (int unsigned k = 0; k < NM; k++) begin
                idx = 32'(ptr_q[j]) + k;
                if (idx >= NM) idx = idx - NM;
                if (!found[j] && tgt[j][idx]) begin
                    found[j] = 1'b1;
                    pick[j]  = GW'(idx);
                end
            end
        end
    end

    // Bus steering; a master targets one slave at a time, so no m_ack conflicts.
    always_comb begin
        logic [GW-1:0] g;
        g           = '0;
        bus.s_req   = '0;
        bus.s_addr  = '0;
        bus.s_cmd   = '0;
        bus.s_wdata = '0;
        bus.m_ack   = '0;
        bus.m_rdata = '0;
        for (int unsigned j = 0; j < NS; j++) begin
            if (state_q[j] == BUSY) begin
                g                        = gnt_q[j];
                bus.s_req[j]             = bus.m_req[g];
                bus.s_addr[j*AW +: AW]   = bus.m_addr[g*AW +: AW];
                bus.s_cmd[j]             = bus.m_cmd[g];
                bus.s_wdata[j*DW +: DW]  = bus.m_wdata[g*DW +: DW];
                if (bus.s_ack[j]) begin
                    bus.m_ack[g]            = 1'b1;
                    bus.m_rdata[g*DW +: DW] = bus.s_rdata[j*DW +: DW];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned j = 0; j < NS; j++) begin
                state_q[j] <= IDLE;
                gnt_q[j]   <= '0;
                ptr_q[j]   <= '0;
            end
        end else begin
            for (int unsigned j = 0; j < NS; j++) begin
                case (state_q[j])
                    IDLE: begin
                        if (found[j]) begin
                            gnt_q[j]   <= pick[j];
                            state_q[j] <= BUSY;
                        end
                    end
                    BUSY: begin
                        // Ack outranks a same-cycle req drop; a drop alone keeps rr_ptr.
                        if (bus.s_ack[j]) begin
                            state_q[j] <= IDLE;
                            ptr_q[j]   <= (32'(gnt_q[j]) == NM-1) ? '0 : gnt_q[j] + 1'b1;
                        end else if (!bus.m_req[gnt_q[j]]) begin
                            state_q[j] <= IDLE;
                        end
                    end
                    default: state_q[j] <= IDLE;
                endcase
            end
        end
    end
endmodule
